// File: rtl/instr_fetch.sv
// instr_fetch: program counter and next-PC stage for the single-cycle core.
// Holds the 64-bit PC, presents it to a combinational instruction memory and
// forwards the fetched word downstream. Next PC is chosen, in priority order,
// from hold (stall), register target (BR), PC-relative branch (B / CBZ /
// B.cond) and sequential +4. An unconditional branch with zero offset is
// treated as a halt.
//
// Optional build macro: IFETCH_RETIRE_CNT_EN adds the `retired` port and a
// 32-bit count of issued instructions.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_START | first cycle after reset; NOP presented, PC not advanced
// ST_RUN   | normal fetch; imem word forwarded, PC follows next-PC rules
// ST_HALT  | branch-to-self seen; NOP presented, PC frozen until reset

module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_WORD = 32'hD503201F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        BrTaken,
  input  logic        UncondBr,
  input  logic        BrReg,
  input  logic [63:0] br_target,
  input  logic [31:0] imem_rdata,
  output logic [63:0] pc,
  output logic [31:0] instruction,
  output logic        halted
`ifdef IFETCH_RETIRE_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] br_offset;
  logic [63:0] br_sum;
  logic [63:0] seq_pc;
  logic        halt_hit;

  // Forward the fetched word only while running; START and HALT issue a NOP.
  always_comb begin
    instruction = (state == ST_RUN) ? imem_rdata : NOP_WORD;
  end

  // Branch offset: sign-extended word offset, scaled to bytes.
  always_comb begin
    if (UncondBr) begin
      br_offset = {{36{instruction[25]}}, instruction[25:0], 2'b00};
    end else begin
      br_offset = {{43{instruction[23]}}, instruction[23:5], 2'b00};
    end
    br_sum   = pc + br_offset;
    seq_pc   = pc + 64'd4;
    halt_hit = UncondBr && (instruction[25:0] == 26'd0);
  end

  // Sequencing FSM with registered PC and halt flag; a stalled branch is
  // simply dropped since control re-asserts it once the stall clears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_START;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_START: begin
          if (!stall) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!stall) begin
            if (BrReg) begin
              pc <= br_target;
            end else if (BrTaken) begin
              pc <= br_sum;
              if (halt_hit) begin
                state  <= ST_HALT;
                halted <= 1'b1;
              end
            end else begin
              pc <= seq_pc;
            end
          end
        end
        ST_HALT: begin
        end
        default: begin
          state <= ST_START;
        end
      endcase
    end
  end

`ifdef IFETCH_RETIRE_CNT_EN
  // Count every unstalled RUN cycle, the halting branch included; wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      retired <= 32'd0;
    end else if (state == ST_RUN && !stall) begin
      retired <= retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed vectors with literal expectations plus
// a behavioural next-PC model compared against the DUT every cycle.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        BrTaken;
  logic        UncondBr;
  logic        BrReg;
  logic [63:0] br_target;
  logic [31:0] imem_rdata;
  logic [63:0] pc;
  logic [31:0] instruction;
  logic        halted;
`ifdef IFETCH_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .BrTaken     (BrTaken),
    .UncondBr    (UncondBr),
    .BrReg       (BrReg),
    .br_target   (br_target),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .instruction (instruction),
    .halted      (halted)
`ifdef IFETCH_RETIRE_CNT_EN
    ,
    .retired     (retired)
`endif
  );

  always #5 clk = ~clk;

  // Sparse instruction memory; unlisted addresses return a patterned word
  // whose low bit is set so it can never look like a branch-to-self.
  logic [31:0] imem [bit [63:0]];

  function automatic logic [31:0] imem_word(input logic [63:0] a);
    if (imem.exists(a)) return imem[a];
    return 32'h8B000001 | {6'd0, a[25:0]};
  endfunction

  assign imem_rdata = imem_word(pc);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: mode 0 = idle after reset, 1 = issuing, 2 = halted.
  int          m_mode = 0;
  logic [63:0] m_pc   = 64'd0;
  logic        m_halt = 1'b0;
  logic [31:0] m_ret  = 32'd0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    logic [31:0] w;
    longint      off;
    if (!reset) begin
      m_mode = 0;
      m_pc   = 64'd0;
      m_halt = 1'b0;
      m_ret  = 32'd0;
      chk_en = 1'b1;
    end else if (m_mode == 0) begin
      if (!stall) m_mode = 1;
    end else if (m_mode == 1 && !stall) begin
      m_ret = m_ret + 1;
      w = imem_word(m_pc);
      if (BrReg) begin
        m_pc = br_target;
      end else if (BrTaken) begin
        if (UncondBr) off = longint'($signed(w[25:0]));
        else          off = longint'($signed(w[23:5]));
        m_pc = m_pc + 64'(off * 4);
        if (UncondBr && off == 0) begin
          m_mode = 2;
          m_halt = 1'b1;
        end
      end else begin
        m_pc = m_pc + 64'd4;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_model", pc, m_pc);
      chk("instr_model", {32'd0, instruction},
          {32'd0, (m_mode == 1) ? imem_word(m_pc) : NOP});
      chk("halted_model", {63'd0, halted}, {63'd0, m_halt});
`ifdef IFETCH_RETIRE_CNT_EN
      chk("retired_model", {32'd0, retired}, {32'd0, m_ret});
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 0; BrTaken = 0; UncondBr = 0; BrReg = 0;
  endtask

  task automatic goto(input logic [63:0] a);
    clear_ctl();
    BrReg = 1; br_target = a;
    step();
    BrReg = 0;
    chk("goto_pc", pc, a);
  endtask

  initial begin
    logic [31:0] r0;
    imem[64'h10]   = 32'h54000060;  // cond, imm19 = 3
    imem[64'h24]   = 32'h540000A0;  // cond, imm19 = 5
    imem[64'h40]   = 32'h17FFFFFE;  // B, imm26 = -2
    imem[64'h80]   = 32'h14000000;  // B to self
    imem[64'h1000] = 32'h54FFFFE0;  // cond, imm19 = -1
    r0 = 32'd0;

    reset = 0; br_target = 64'd0;
    clear_ctl();
    step(); step();
    chk("rst_pc", pc, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
`ifdef IFETCH_RETIRE_CNT_EN
    chk("rst_retired", {32'd0, retired}, 64'd0);
`endif

    // Release: one START cycle, then sequential fetch from 0.
    reset = 1;
    #1;
    chk("start_instr", {32'd0, instruction}, {32'd0, NOP});
    chk("start_pc", pc, 64'd0);
    step(); chk("run0_pc", pc, 64'h0);
    chk("run0_instr", {32'd0, instruction}, 64'h8B000001);
    step(); chk("run1_pc", pc, 64'h4);
    step(); chk("run2_pc", pc, 64'h8);
    step(); chk("run3_pc", pc, 64'hC);
    step(); chk("run4_pc", pc, 64'h10);

    // Conditional forward branch, then same again with BR winning.
    BrTaken = 1; UncondBr = 0;
    step(); chk("cond_fwd", pc, 64'h1C);
    goto(64'h10);
    BrTaken = 1; UncondBr = 0; BrReg = 1; br_target = 64'h200;
    step(); chk("br_prio", pc, 64'h200);

    // Unconditional backward and conditional negative offsets.
    goto(64'h40);
    BrTaken = 1; UncondBr = 1;
    step(); chk("uncond_back", pc, 64'h38);
    goto(64'h1000);
    BrTaken = 1; UncondBr = 0;
    step(); chk("cond_neg", pc, 64'hFFC);

    // BR alongside a branch-to-self word: no halt.
    goto(64'h80);
    BrTaken = 1; UncondBr = 1; BrReg = 1; br_target = 64'h300;
    step(); chk("br_nohalt_pc", pc, 64'h300);
    chk("br_nohalt_h", {63'd0, halted}, 64'd0);

    // Stall with pending branch.
    goto(64'h24);
`ifdef IFETCH_RETIRE_CNT_EN
    r0 = retired;
`endif
    stall = 1; BrTaken = 1; UncondBr = 0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_pc", pc, 64'h24);
`ifdef IFETCH_RETIRE_CNT_EN
      chk("stall_ret", {32'd0, retired}, {32'd0, r0});
`endif
    end
    stall = 0; BrTaken = 0;
    step(); chk("stall_rel", pc, 64'h28);

    // Wrap past the top of the address space; unmasked BR target.
    goto(64'hFFFF_FFFF_FFFF_FFFC);
    step(); chk("wrap_pc", pc, 64'h0);
    goto(64'h103);
    chk("br_unmasked", pc, 64'h103);

    // Halt on branch-to-self.
    goto(64'h80);
    chk("halt_word", {32'd0, instruction}, 64'h14000000);
    BrTaken = 1; UncondBr = 1;
    step();
    chk("halt_flag", {63'd0, halted}, 64'd1);
    chk("halt_pc", pc, 64'h80);
    chk("halt_instr", {32'd0, instruction}, {32'd0, NOP});
    br_target = 64'h500;
    for (int i = 0; i < 10; i++) begin
      stall = i[0]; BrTaken = 1; UncondBr = i[1]; BrReg = i[2];
      step(); chk("halt_hold", pc, 64'h80);
    end

    // Reset out of HALT, then a stalled START.
    clear_ctl();
    reset = 0;
    step();
    chk("rst_halt_pc", pc, 64'h0);
    chk("rst_halt_h", {63'd0, halted}, 64'd0);
    reset = 1; stall = 1;
    step(); chk("start_stall_i", {32'd0, instruction}, {32'd0, NOP});
    step(); chk("start_stall_p", pc, 64'h0);
    stall = 0;
    step(); chk("after_start", pc, 64'h0);
    step(); chk("after_start4", pc, 64'h4);

    // Reset overrides an in-flight branch.
    BrTaken = 1; UncondBr = 1; reset = 0;
    step(); chk("rst_branch", pc, 64'h0);
    clear_ctl(); reset = 1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Program-counter and next-PC stage that feeds the 32-bit instruction word into the single-cycle datapath and its control decoder. It holds the 64-bit PC, presents it to the instruction memory, and forwards the returned word downstream. It computes the next PC from sequential, unconditional (B), conditional (CBZ/B.cond) and register (BR) targets, and detects a branch-to-self halt. Branch decisions (`BrTaken`, `UncondBr`, `BrReg`) come from control logic that consumes the datapath's `zero` and flag-register outputs.

## Interface
Parameters:
- `RESET_PC`, 64'h0, PC value loaded on reset.
- `NOP_WORD`, 32'hD503201F, word driven on `instruction` during the START cycle.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `stall`  in  1  hold PC and state this cycle.
- `BrTaken`  in  1  take a PC-relative branch.
- `UncondBr`  in  1  when 1, offset = `instruction[25:0]`; when 0, offset = `instruction[23:5]`.
- `BrReg`  in  1  next PC = `br_target` (BR).
- `br_target`  in  64  register-file value for BR.
- `imem_rdata`  in  32  instruction memory read data for address `pc`. Combinational memory.
- `pc`  out  64  current PC, also the instruction memory address.
- `instruction`  out  32  word to the datapath and decoder.
- `halted`  out  1  1 once a halt is detected.
- `retired`  out  32  count of instructions issued. Present only with `IFETCH_RETIRE_CNT_EN`.

## Operation
- States: START, RUN, HALT.
- Reset (`reset`=0 at an edge):
  - `pc`=`RESET_PC`, state=START, `halted`=0, `retired`=0.
  - Reset overrides every other input in any state, including mid-branch and HALT.
- START:
  - `instruction`=`NOP_WORD`.
  - PC is not updated.
  - Next edge goes to RUN unless `stall`=1, in which case it stays in START.
- RUN:
  - `instruction`=`imem_rdata`.
  - Next-PC priority:
    1. `stall` → hold.
    2. `BrReg` → `br_target`.
    3. `BrTaken` → `pc + (sext(offset) << 2)`.
    4. Otherwise → `pc + 4`.
- Arithmetic:
  - The 26-bit or 19-bit offset is sign-extended to 64 bits and shifted left 2.
  - All additions are modulo 2^64; wrap past 64'hFFFF_FFFF_FFFF_FFFC to 0 is legal and silent.
  - `br_target` is used unmodified; the low 2 bits are not masked.
- Halt detection:
  - Condition, in RUN: `stall`=0, `BrTaken`=1, `UncondBr`=1, `instruction[25:0]`=0.
  - At that edge: state→HALT, `halted`→1, `pc` is unchanged (equal to the computed target).
- HALT:
  - `instruction`=`NOP_WORD`.
  - `pc` is frozen; all branch and stall inputs are ignored.
  - Only reset leaves HALT.
- Simultaneous inputs:
  - `BrReg` and `BrTaken` both 1: `BrReg` wins; no halt check.
  - `stall` with a branch: the branch is dropped. Control re-asserts it on the unstalled cycle because the instruction is unchanged.

## Timing
- `pc`, state, `halted` and `retired` are registered.
- `instruction` is combinational from `imem_rdata` and state; no added latency.
- A branch decided in cycle N redirects `pc` at the edge ending cycle N. The target instruction appears in cycle N+1 with no bubble.
- After reset deasserts: exactly one START cycle (NOP), then the first real instruction from `RESET_PC`.
- `halted` rises at the edge that commits the halt. The cycle containing the halting branch still presents the real branch word.

## Configuration
- `IFETCH_RETIRE_CNT_EN` defined:
  - Port `retired` and a 32-bit counter exist.
  - The counter increments by 1 at each edge where state=RUN and `stall`=0, including the halting branch.
  - It wraps from 32'hFFFFFFFF to 0 and holds in START, HALT and stall cycles.
- Not defined:
  - No `retired` port and no counter logic.
  - All other behaviour is identical.

## Test plan
- Reset then free-run: hold `reset`=0 for 2 cycles, release.
  - Cycle 1: `instruction`=D503201F, `pc`=0.
  - Following cycles: `pc` sequence 0,4,8,C; `instruction` tracks `imem_rdata`.
- Unconditional backward branch: at `pc`=0x40, `BrTaken`=1, `UncondBr`=1, `instruction[25:0]`=26'h3FFFFFE (−2) → next `pc`=0x38.
- Conditional forward branch and BR priority:
  - At `pc`=0x10, `UncondBr`=0, `instruction[23:5]`=3, `BrTaken`=1 → `pc`=0x1C.
  - Same cycle with `BrReg`=1, `br_target`=0x200 → `pc`=0x200.
- Stall: assert `stall` for 3 cycles at `pc`=0x24 with `BrTaken`=1.
  - `pc` stays 0x24 and `retired` does not change.
  - After release with `BrTaken`=0 → `pc`=0x28.
- Halt: branch-to-self at `pc`=0x80.
  - `halted`=1 next cycle, `pc`=0x80 held for 10 cycles, `instruction`=D503201F.
  - Pulsing `reset`=0 returns `pc`=0 and `halted`=0.
- Wrap and counter:
  - `br_target`=64'hFFFFFFFFFFFFFFFC via BR, then a sequential step → `pc`=0.
  - With `IFETCH_RETIRE_CNT_EN`: `retired` equals the count of unstalled RUN cycles.
